// File: rtl/pc_branch_unit_if.sv
// Purpose: bus bundle between the test harness/decoder and the PC/branch unit.
// Ports (as seen by the unit through the slave modport):
//   in : start, halt, stall, jump_en, branch_en, branch_on_zero, zero,
//        target_idx[IDX_W], lut_we, lut_waddr[IDX_W], lut_wdata[PC_W]
//   out: pc[PC_W], running, done, taken_count[CNT_W]
interface pc_branch_unit_if #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic             halt;
  logic             stall;
  logic             jump_en;
  logic             branch_en;
  logic             branch_on_zero;
  logic             zero;
  logic [IDX_W-1:0] target_idx;
  logic             lut_we;
  logic [IDX_W-1:0] lut_waddr;
  logic [PC_W-1:0]  lut_wdata;
  logic [PC_W-1:0]  pc;
  logic             running;
  logic             done;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output start, halt, stall, jump_en, branch_en, branch_on_zero, zero,
           target_idx, lut_we, lut_waddr, lut_wdata,
    input  pc, running, done, taken_count
  );

  modport slave (
    input  start, halt, stall, jump_en, branch_en, branch_on_zero, zero,
           target_idx, lut_we, lut_waddr, lut_wdata,
    output pc, running, done, taken_count
  );
endinterface

// File: rtl/pc_branch_unit.sv
// Purpose: program-counter / branch-resolution stage. Produces the next
// instruction ROM address each cycle; jump/branch targets come from an
// internal LUT indexed by target_idx. Includes run/halt control and a
// saturating count of taken redirects.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst   : asynchronous active-high reset
//   io_bus  : pc_branch_unit_if.slave (control in, pc/status out)
module pc_branch_unit #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  pc_branch_unit_if.slave     io_bus
);

  localparam int unsigned LUT_N = 2 ** IDX_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [PC_W-1:0]  r_lut [LUT_N];
  logic [PC_W-1:0]  w_target;
  logic             w_taken;

  // Target read uses pre-edge LUT contents, so a same-cycle write is not seen
  assign w_target = r_lut[io_bus.target_idx];
  // Jump wins over branch; a simultaneous jump+branch is counted once
  assign w_taken  = io_bus.jump_en |
                    (io_bus.branch_en & (io_bus.zero == io_bus.branch_on_zero));

  // State, PC and counter registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state / next-PC / counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE, S_HALTED: begin
        if (io_bus.start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = '0;
          w_cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        if (io_bus.halt) begin
          w_state_nxt = S_HALTED;
        end else if (io_bus.stall) begin
          w_pc_nxt = r_pc;
        end else if (w_taken) begin
          w_pc_nxt = w_target;
          if (r_cnt != {CNT_W{1'b1}}) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_pc_nxt = r_pc + PC_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pc_nxt    = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Target LUT: writable in every state, cleared by reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < LUT_N; i++) begin
        r_lut[i] <= '0;
      end
    end else if (io_bus.lut_we) begin
      r_lut[io_bus.lut_waddr] <= io_bus.lut_wdata;
    end
  end

  assign io_bus.pc          = r_pc;
  assign io_bus.taken_count = r_cnt;
  assign io_bus.running     = (r_state == S_RUN);
  assign io_bus.done        = (r_state == S_HALTED);

endmodule

// File: tb/tb_pc_branch_unit.sv
// Purpose: directed self-checking bench for pc_branch_unit.
module tb_pc_branch_unit;

  localparam int unsigned PC_W  = 10;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pc_branch_unit_if #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

  pc_branch_unit #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ctrl();
    bus.start = 0; bus.halt = 0; bus.stall = 0; bus.jump_en = 0;
    bus.branch_en = 0; bus.branch_on_zero = 0; bus.zero = 0;
    bus.target_idx = '0; bus.lut_we = 0; bus.lut_waddr = '0; bus.lut_wdata = '0;
  endtask

  task automatic lut_wr(input int idx, input int val);
    bus.lut_we = 1; bus.lut_waddr = IDX_W'(idx); bus.lut_wdata = PC_W'(val);
    step();
    bus.lut_we = 0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clr_ctrl();
    rst = 1;
    #22 rst = 0;

    // Run a little, then reset mid-cycle
    bus.start = 1; step(); bus.start = 0;
    chk("start_pc", 32'(bus.pc), 32'h0);
    step(); step();
    chk("run_pc2", 32'(bus.pc), 32'h2);
    chk("run_running", 32'(bus.running), 32'h1);
    #2 rst = 1;
    #1;
    chk("rst_pc", 32'(bus.pc), 32'h0);
    chk("rst_running", 32'(bus.running), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_cnt", 32'(bus.taken_count), 32'h0);
    rst = 0;
    step();

    // Idle: LUT write accepted, jumps ignored
    lut_wr(2, 'h55);
    bus.jump_en = 1; bus.target_idx = 2;
    for (int i = 0; i < 5; i++) step();
    chk("idle_pc", 32'(bus.pc), 32'h0);
    chk("idle_running", 32'(bus.running), 32'h0);
    chk("idle_cnt", 32'(bus.taken_count), 32'h0);
    bus.jump_en = 0;

    // Increment and wrap
    bus.start = 1; step(); bus.start = 0;
    chk("run_from0", 32'(bus.pc), 32'h0);
    for (int i = 0; i < 1023; i++) step();
    chk("pc_max", 32'(bus.pc), 32'h3FF);
    step();
    chk("pc_wrap", 32'(bus.pc), 32'h0);

    // Conditional branch
    lut_wr(3, 'h120);                       // pc -> 1
    bus.branch_en = 1; bus.target_idx = 3;
    bus.branch_on_zero = 1; bus.zero = 0; step();
    chk("br_nt_pc", 32'(bus.pc), 32'h2);
    chk("br_nt_cnt", 32'(bus.taken_count), 32'h0);
    bus.zero = 1; step();
    chk("br_z_pc", 32'(bus.pc), 32'h120);
    chk("br_z_cnt", 32'(bus.taken_count), 32'h1);
    bus.branch_on_zero = 0; bus.zero = 0; step();
    chk("br_nz_pc", 32'(bus.pc), 32'h120);
    chk("br_nz_cnt", 32'(bus.taken_count), 32'h2);
    bus.zero = 1; step();
    chk("br_nz_nt_pc", 32'(bus.pc), 32'h121);
    bus.branch_en = 0;

    // LUT write/read collision
    lut_wr(5, 'h010);                       // pc -> 0x122
    bus.lut_we = 1; bus.lut_waddr = 5; bus.lut_wdata = 'h200;
    bus.jump_en = 1; bus.target_idx = 5; step();
    bus.lut_we = 0;
    chk("coll_pc", 32'(bus.pc), 32'h010);
    chk("coll_cnt", 32'(bus.taken_count), 32'h3);
    step();
    chk("coll_next_pc", 32'(bus.pc), 32'h200);
    // Jump + failing branch together: jump, counted once
    bus.branch_en = 1; bus.branch_on_zero = 1; bus.zero = 0; step();
    chk("jb_pc", 32'(bus.pc), 32'h200);
    chk("jb_cnt", 32'(bus.taken_count), 32'h5);
    bus.branch_en = 0; bus.jump_en = 0;

    // Priority and halt/restart
    lut_wr(6, 7);                           // pc -> 0x201
    bus.jump_en = 1; bus.target_idx = 6; step();
    chk("to7_pc", 32'(bus.pc), 32'h7);
    bus.halt = 1; bus.stall = 1; step();
    bus.halt = 0; bus.stall = 0;
    chk("halt_pc", 32'(bus.pc), 32'h7);
    chk("halt_done", 32'(bus.done), 32'h1);
    chk("halt_running", 32'(bus.running), 32'h0);
    chk("halt_cnt", 32'(bus.taken_count), 32'h6);
    step();                                 // jump_en still high while halted
    chk("halted_hold_pc", 32'(bus.pc), 32'h7);
    bus.jump_en = 0;
    bus.start = 1; step(); bus.start = 0;
    chk("restart_pc", 32'(bus.pc), 32'h0);
    chk("restart_cnt", 32'(bus.taken_count), 32'h0);
    chk("restart_running", 32'(bus.running), 32'h1);
    step();
    bus.stall = 1; bus.jump_en = 1; step();
    chk("stall_pc", 32'(bus.pc), 32'h1);
    chk("stall_cnt", 32'(bus.taken_count), 32'h0);
    bus.stall = 0;

    // Saturation
    for (int i = 0; i < 300; i++) step();
    chk("sat_cnt", 32'(bus.taken_count), 32'hFF);
    chk("sat_pc", 32'(bus.pc), 32'h7);

    // Reset while jumping, LUT must come back cleared
    #2 rst = 1;
    #1;
    chk("rst2_pc", 32'(bus.pc), 32'h0);
    chk("rst2_running", 32'(bus.running), 32'h0);
    chk("rst2_cnt", 32'(bus.taken_count), 32'h0);
    rst = 0;
    bus.jump_en = 0;
    step();
    bus.start = 1; step(); bus.start = 0;
    step();
    chk("post_rst_inc", 32'(bus.pc), 32'h1);
    bus.jump_en = 1; bus.target_idx = 6; step();
    chk("lut6_cleared", 32'(bus.pc), 32'h0);
    chk("post_rst_cnt", 32'(bus.taken_count), 32'h1);
    step();
    bus.target_idx = 3; step();
    chk("lut3_cleared", 32'(bus.pc), 32'h0);
    bus.jump_en = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
